// File: rtl/c_align.sv
// Fetch-side instruction aligner: turns word-aligned fetch words into one 16- or
// 32-bit instruction per handshake, stitching 32-bit instructions across words.
module c_align #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        fw_valid_i,
  input  logic [31:0] fw_data_i,
  output logic        fw_ready_o,
  output logic        ins_valid_o,
  input  logic        ins_ready_i,
  output logic [31:0] ins_o,
  output logic        ins_c_o,
  output logic [31:0] ins_pc_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HALF  = 2'd1;
  localparam logic [1:0] S_SKIP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] hb_q, hb_d;
  logic [31:0] pc_q, pc_d;
  logic        hs;
  logic        fw_c;
  logic        hb_c;

  assign fw_c = (fw_data_i[1:0] != 2'b11);
  assign hb_c = (hb_q[1:0] != 2'b11);
  assign hs   = ins_valid_o & ins_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_PC[1] ? S_SKIP : S_EMPTY;
      pc_q    <= {RESET_PC[31:1], 1'b0};
      hb_q    <= 16'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hb_q    <= hb_d;
    end
  end

  // Flush overrides any handshake or SKIP consumption in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    hb_d    = hb_q;
    if (flush_i) begin
      state_d = flush_pc_i[1] ? S_SKIP : S_EMPTY;
      pc_d    = {flush_pc_i[31:1], 1'b0};
      hb_d    = 16'h0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (hs) begin
            if (fw_c) begin
              hb_d    = fw_data_i[31:16];
              state_d = S_HALF;
              pc_d    = pc_q + 32'd2;
            end else begin
              pc_d    = pc_q + 32'd4;
            end
          end
        end
        S_HALF: begin
          if (hs) begin
            if (hb_c) begin
              state_d = S_EMPTY;
              pc_d    = pc_q + 32'd2;
            end else begin
              hb_d    = fw_data_i[31:16];
              pc_d    = pc_q + 32'd4;
            end
          end
        end
        S_SKIP: begin
          if (fw_valid_i) begin
            hb_d    = fw_data_i[31:16];
            state_d = S_HALF;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Handshake: a word or instruction transfers in a cycle where valid and ready are both high.
  always_comb begin
    ins_valid_o = 1'b0;
    fw_ready_o  = 1'b0;
    ins_o       = 32'h0;
    ins_c_o     = 1'b0;
    ins_pc_o    = pc_q;
    if (!rst && !flush_i) begin
      case (state_q)
        S_EMPTY: begin
          ins_valid_o = fw_valid_i;
          if (fw_valid_i) begin
            ins_o   = fw_c ? {16'h0, fw_data_i[15:0]} : fw_data_i;
            ins_c_o = fw_c;
          end
          fw_ready_o = fw_valid_i & ins_ready_i;
        end
        S_HALF: begin
          if (hb_c) begin
            ins_valid_o = 1'b1;
            ins_o       = {16'h0, hb_q};
            ins_c_o     = 1'b1;
          end else begin
            ins_valid_o = fw_valid_i;
            ins_o       = {fw_data_i[15:0], hb_q};
            fw_ready_o  = fw_valid_i & ins_ready_i;
          end
        end
        S_SKIP: fw_ready_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/c_align.md
Name: c_align

Overview:
- Fetch-side instruction aligner. It sits directly upstream of the compressed-instruction expander and decode.
- Consumes an in-order stream of 32-bit, word-aligned fetch words. Emits one instruction per handshake: either a 16-bit compressed instruction or a full 32-bit one, including 32-bit instructions that straddle two fetch words.
- Tracks the PC of each emitted instruction and supports redirects to halfword-aligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 is ignored.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  redirect; discard all buffered state.
- flush_pc_i  in  32  redirect target; bit 0 is ignored.
- fw_valid_i  in  1  fetch word valid.
- fw_data_i  in  32  fetch word, little-endian halfwords.
- fw_ready_o  out  1  fetch word accepted this cycle when high together with fw_valid_i.
- ins_valid_o  out  1  instruction valid.
- ins_ready_i  in  1  downstream accepts the instruction.
- ins_o  out  32  instruction; when compressed, [15:0] is the instruction and [31:16] = 0.
- ins_c_o  out  1  1 = compressed (ins_o[1:0] != 2'b11).
- ins_pc_o  out  32  PC of ins_o; bit 0 is always 0.

Behaviour:
- Fetch contract: after reset or flush, the fetch unit restarts the stream at {pc[31:2],2'b00}. Words presented in the flush cycle are dropped.
- Storage: hb[15:0] halfword buffer; pc[31:0]; state register.
- States:
  - EMPTY: no halfword buffered.
  - HALF: hb holds the next instruction's low halfword.
  - SKIP: the next fetch word's low half must be discarded.
- Reset: state = RESET_PC[1] ? SKIP : EMPTY; pc = {RESET_PC[31:1],1'b0}; hb = 0. During reset: ins_valid_o = 0, fw_ready_o = 0, ins_o = 0, ins_c_o = 0, ins_pc_o = pc.
- Output path is combinational from state, hb and fw_data_i. There is no added latency.
  - ins_valid_o must not depend on ins_ready_i.
  - fw_ready_o may depend on ins_ready_i.
- Let hs = ins_valid_o & ins_ready_i.
- EMPTY:
  - fw_valid_i = 0: ins_valid_o = 0, fw_ready_o = 0.
  - fw_data_i[1:0] != 11: compressed. ins_o = {16'h0, fw[15:0]}, ins_c_o = 1. On hs: word consumed, hb <= fw[31:16], state <= HALF, pc += 2.
  - fw_data_i[1:0] == 11: ins_o = fw, ins_c_o = 0. On hs: word consumed, state stays EMPTY, pc += 4.
  - fw_ready_o = hs.
- HALF:
  - hb[1:0] != 11: ins_valid_o = 1, ins_o = {16'h0, hb}, ins_c_o = 1, fw_ready_o = 0. On hs: state <= EMPTY, pc += 2.
  - hb[1:0] == 11 (straddle): ins_valid_o = fw_valid_i, ins_o = {fw[15:0], hb}, ins_c_o = 0. On hs: word consumed, hb <= fw[31:16], state stays HALF, pc += 4. fw_ready_o = hs.
- SKIP:
  - ins_valid_o = 0, fw_ready_o = 1.
  - On fw_valid_i: hb <= fw[31:16], state <= HALF. pc is unchanged (it already points at the upper half). This costs one bubble cycle.
- Flush:
  - While flush_i = 1: ins_valid_o = 0, fw_ready_o = 0.
  - Next state: pc <= {flush_pc_i[31:1],1'b0}; state <= flush_pc_i[1] ? SKIP : EMPTY; hb <= 0.
  - Flush has priority over any handshake or SKIP consumption in the same cycle.
  - rst has priority over flush.
- Backpressure: while ins_valid_o = 1 and ins_ready_i = 0, ins_o, ins_c_o and ins_pc_o are held stable (inputs permitting), and no state or pc changes occur.
- pc arithmetic: 32-bit modulo; it wraps from 0xFFFF_FFFE/0xFFFF_FFFC to 0 without error.
- No illegal-instruction detection here; all halfword patterns are passed on.

Test Plan:
1. Reset, RESET_PC = 0, ins_ready = 1, word 0x0000_0013 -> ins_o = 0x0000_0013, c = 0, pc = 0; next pc = 4; state EMPTY.
2. Word 0x4501_4501 -> cycle 1: ins_o = 0x0000_4501, pc = 0, fw_ready = 1. Cycle 2: ins_o = 0x0000_4501, pc = 2, fw_ready = 0. One word consumed in total.
3. Words 0x0013_4501 then 0x1234_0000 -> c 0x4501 @0; 32-bit 0x0000_0013 @2 (straddle, second word consumed); c 0x1234 @6 from buffer.
4. flush_i with flush_pc = 0x0000_0102, then word 0x4501_ABCD -> one bubble (SKIP, fw_ready = 1, ins_valid = 0); then ins_o = 0x0000_4501, c = 1, pc = 0x102.
5. ins_ready = 0 for 3 cycles with a valid straddled instruction -> ins_o and pc stable, fw_ready = 0, hb unchanged; it completes on the 4th cycle.
6. flush_i asserted in the same cycle as hs, target 0x200 -> no pc advance from hs; next cycle pc = 0x200, state EMPTY, the previously buffered halfword is never emitted.
